// File: rtl/udm_host_link.sv
// Host end of the UART debug-monitor link: turns single-word bus reads/writes
// into UDM command frames over an 8N1 UART and collects the 4-byte read reply.
`timescale 1ns/1ps
module udm_host_link #(
  parameter int baud_div   = 434,
  parameter int rx_timeout = 1000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bus_req_i,
  input  logic        bus_we_i,
  input  logic [31:0] bus_addr_i,
  input  logic [31:0] bus_wdata_i,
  output logic        bus_ack_o,
  output logic        bus_resp_o,
  output logic [31:0] bus_rdata_o,
  output logic        timeout_o,
  output logic        busy_o,
  input  logic        rx_i,
  output logic        tx_o
);

  localparam logic [15:0] BAUD_LAST = 16'(baud_div - 1);
  localparam logic [15:0] BAUD_HALF = 16'(baud_div / 2 - 1);
  localparam logic [31:0] TMO_LAST  = 32'(rx_timeout - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} seq_t;
  typedef enum logic [1:0] {R_HUNT, R_START, R_DATA, R_STOP} rx_t;

  seq_t        state_q, state_d;
  rx_t         rx_state_q, rx_state_d;

  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [15:0] tx_cnt;
  logic [3:0]  tx_bit, tx_byte;
  logic        tx_q;
  logic [7:0]  cur_byte;
  logic        accept, tx_tick, tx_last_byte, tx_end;

  logic        rx_p0, rx_p1, rx_p2;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_tick, rx_vld;

  logic [31:0] tmo_cnt;
  logic [1:0]  rsp_cnt;
  logic [23:0] rsp_asm;
  logic        tmo_q, rsp_byte, rsp_last, tmo_hit;

  // Byte idx of the command frame: sync, cmd, addr LSB-first, length, data.
  function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic is_wr,
                                            input logic [31:0] a, input logic [31:0] d);
    case (idx)
      4'd0:    frame_byte = 8'h55;
      4'd1:    frame_byte = is_wr ? 8'h81 : 8'h82;
      4'd2:    frame_byte = a[7:0];
      4'd3:    frame_byte = a[15:8];
      4'd4:    frame_byte = a[23:16];
      4'd5:    frame_byte = a[31:24];
      4'd6:    frame_byte = 8'h04;
      4'd10:   frame_byte = d[7:0];
      4'd11:   frame_byte = d[15:8];
      4'd12:   frame_byte = d[23:16];
      4'd13:   frame_byte = d[31:24];
      default: frame_byte = 8'h00;
    endcase
  endfunction

  function automatic logic tx_level(input logic [3:0] bit_idx, input logic [7:0] b);
    if (bit_idx == 4'd0)      tx_level = 1'b0;
    else if (bit_idx >= 4'd9) tx_level = 1'b1;
    else                      tx_level = b[3'(bit_idx - 4'd1)];
  endfunction

  assign accept       = (state_q == S_IDLE) && bus_req_i;
  assign cur_byte     = frame_byte(tx_byte, we_q, addr_q, wdata_q);
  assign tx_tick      = (tx_cnt == BAUD_LAST);
  assign tx_last_byte = (tx_byte == (we_q ? 4'd13 : 4'd9));
  assign tx_end       = (state_q == S_SEND) && tx_tick && (tx_bit == 4'd9) && tx_last_byte;

  assign rx_tick  = (rx_state_q == R_START) ? (rx_cnt == BAUD_HALF) : (rx_cnt == BAUD_LAST);
  assign rx_vld   = (rx_state_q == R_STOP) && rx_tick && rx_p1;
  assign rsp_byte = (state_q == S_WAIT) && rx_vld;
  assign rsp_last = rsp_byte && (rsp_cnt == 2'd3);
  assign tmo_hit  = (state_q == S_WAIT) && (tmo_cnt == TMO_LAST);

  assign bus_ack_o  = (state_q == S_IDLE);
  assign busy_o     = (state_q == S_SEND) || (state_q == S_WAIT);
  assign bus_resp_o = (state_q == S_DONE);
  assign timeout_o  = (state_q == S_DONE) && tmo_q;
  assign tx_o       = tx_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus_req_i) state_d = S_SEND;
      S_SEND: if (tx_end) state_d = we_q ? S_DONE : S_WAIT;
      S_WAIT: if (rsp_last || tmo_hit) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Request payload and reply assembly carry no reset; they are qualified by state.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q    <= bus_we_i;
      addr_q  <= bus_addr_i;
      wdata_q <= bus_wdata_i;
    end
    if (rsp_byte) begin
      case (rsp_cnt)
        2'd0:    rsp_asm[7:0]   <= rx_shift;
        2'd1:    rsp_asm[15:8]  <= rx_shift;
        2'd2:    rsp_asm[23:16] <= rx_shift;
        default: ;
      endcase
    end
    if ((rx_state_q == R_DATA) && rx_tick) rx_shift <= {rx_p1, rx_shift[7:1]};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tx_q    <= 1'b1;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_byte <= '0;
    end else if (accept) begin
      tx_q    <= 1'b0;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_byte <= '0;
    end else if (state_q == S_SEND) begin
      if (tx_tick) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          // Next byte starts immediately; after the final stop bit the line stays high.
          if (!tx_last_byte) begin
            tx_byte <= tx_byte + 4'd1;
            tx_bit  <= '0;
            tx_q    <= 1'b0;
          end
        end else begin
          tx_bit <= tx_bit + 4'd1;
          tx_q   <= tx_level(tx_bit + 4'd1, cur_byte);
        end
      end else begin
        tx_cnt <= tx_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      R_HUNT:  if (rx_p2 && !rx_p1) rx_state_d = R_START;
      R_START: if (rx_tick) rx_state_d = rx_p1 ? R_HUNT : R_DATA;
      R_DATA:  if (rx_tick && (rx_bit == 3'd7)) rx_state_d = R_STOP;
      R_STOP:  if (rx_tick) rx_state_d = R_HUNT;
      default: rx_state_d = R_HUNT;
    endcase
  end

  // rx_p0/rx_p1 synchronise the line; rx_p2 is the previous sample for edge detection.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_p0      <= 1'b1;
      rx_p1      <= 1'b1;
      rx_p2      <= 1'b1;
      rx_state_q <= R_HUNT;
      rx_cnt     <= '0;
      rx_bit     <= '0;
    end else begin
      rx_p0      <= rx_i;
      rx_p1      <= rx_p0;
      rx_p2      <= rx_p1;
      rx_state_q <= rx_state_d;
      rx_cnt     <= ((rx_state_q == R_HUNT) || rx_tick) ? 16'd0 : rx_cnt + 16'd1;
      if (rx_state_q != R_DATA) rx_bit <= '0;
      else if (rx_tick)         rx_bit <= rx_bit + 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tmo_cnt     <= '0;
      rsp_cnt     <= '0;
      tmo_q       <= 1'b0;
      bus_rdata_o <= '0;
    end else begin
      tmo_q <= tmo_hit && !rsp_last;
      if (tx_end) begin
        tmo_cnt <= '0;
        rsp_cnt <= '0;
      end else if (state_q == S_WAIT) begin
        tmo_cnt <= tmo_cnt + 32'd1;
        if (rsp_byte) rsp_cnt <= rsp_cnt + 2'd1;
      end
      // A 4th byte arriving on the timeout cycle still counts as success.
      if (rsp_last)     bus_rdata_o <= {rx_shift, rsp_asm};
      else if (tmo_hit) bus_rdata_o <= 32'hFFFF_FFFF;
    end
  end

endmodule

// File: tb/tb_udm_host_link.sv
// Bench for udm_host_link: table vectors, random transactions and reset abort,
// checked against a byte/bit-level model of the UDM frame and reply rules.
`timescale 1ns/1ps
module tb_udm_host_link;

  localparam int BAUD  = 4;
  localparam int TMO_A = 400;
  localparam int TMO_B = 100;
  localparam int RXL   = 2048;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, rx = 1'b1;
  logic [31:0] addr = '0, wdata = '0;
  bit          sel = 1'b0;

  logic ack_a, resp_a, tmo_a, busy_a, tx_a;
  logic ack_b, resp_b, tmo_b, busy_b, tx_b;
  logic [31:0] rdata_a, rdata_b;
  logic m_ack, m_resp, m_tmo, m_busy, m_tx;
  logic [31:0] m_rdata;

  int checks = 0;
  int errors = 0;
  bit rxl[0:RXL-1];

  typedef struct {
    bit        we;
    bit [31:0] addr;
    bit [31:0] wdata;
    int        nreply;
    bit [31:0] reply;
    int        bad_idx;
    bit        glitch;
    bit        inject;
    bit        hold;
    bit        use_b;
    bit [31:0] exp_rdata;
    bit        exp_tmo;
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  udm_host_link #(.baud_div(BAUD), .rx_timeout(TMO_A)) u_dut_a (
    .clk_i(clk), .rst_i(rst_n), .bus_req_i(req & ~sel), .bus_we_i(we),
    .bus_addr_i(addr), .bus_wdata_i(wdata), .bus_ack_o(ack_a), .bus_resp_o(resp_a),
    .bus_rdata_o(rdata_a), .timeout_o(tmo_a), .busy_o(busy_a), .rx_i(rx), .tx_o(tx_a));

  udm_host_link #(.baud_div(BAUD), .rx_timeout(TMO_B)) u_dut_b (
    .clk_i(clk), .rst_i(rst_n), .bus_req_i(req & sel), .bus_we_i(we),
    .bus_addr_i(addr), .bus_wdata_i(wdata), .bus_ack_o(ack_b), .bus_resp_o(resp_b),
    .bus_rdata_o(rdata_b), .timeout_o(tmo_b), .busy_o(busy_b), .rx_i(rx), .tx_o(tx_b));

  assign m_ack   = sel ? ack_b   : ack_a;
  assign m_resp  = sel ? resp_b  : resp_a;
  assign m_tmo   = sel ? tmo_b   : tmo_a;
  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_tx    = sel ? tx_b    : tx_a;
  assign m_rdata = sel ? rdata_b : rdata_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reply model: only bytes with a good stop bit count; four of them make the word.
  function automatic void model(inout vec_t v);
    logic [7:0] good[$];
    for (int j = 0; j < v.nreply; j++)
      if (j != v.bad_idx) good.push_back(v.reply[8*j +: 8]);
    v.exp_tmo   = (good.size() < 4);
    v.exp_rdata = v.exp_tmo ? 32'hFFFF_FFFF : {good[3], good[2], good[1], good[0]};
  endfunction

  task automatic put_byte(input int at, input logic [7:0] b, input bit bad);
    bit lvl;
    for (int k = 0; k < 10; k++) begin
      lvl = (k == 0) ? 1'b0 : (k == 9) ? !bad : b[k-1];
      for (int c = 0; c < BAUD; c++) rxl[at + k*BAUD + c] = lvl;
    end
  endtask

  task automatic run(input vec_t v, input string tag);
    logic [7:0]  fb[$];
    bit          eb[$];
    int          fcyc, tmo, rx_at, lim, resp_n, tx_bad, ctl_bad, w;
    logic [31:0] rd_seen;
    logic        tmo_seen, exp_tx;
    fb = '{8'h55, v.we ? 8'h81 : 8'h82, v.addr[7:0], v.addr[15:8], v.addr[23:16],
           v.addr[31:24], 8'h04, 8'h00, 8'h00, 8'h00};
    if (v.we) begin
      fb.push_back(v.wdata[7:0]);   fb.push_back(v.wdata[15:8]);
      fb.push_back(v.wdata[23:16]); fb.push_back(v.wdata[31:24]);
    end
    foreach (fb[i]) begin
      eb.push_back(1'b0);
      for (int b = 0; b < 8; b++) eb.push_back(fb[i][b]);
      eb.push_back(1'b1);
    end
    fcyc = eb.size() * BAUD;
    tmo  = v.use_b ? TMO_B : TMO_A;
    for (int i = 0; i < RXL; i++) rxl[i] = 1'b1;
    if (v.inject) put_byte(10, 8'hEE, 1'b0);
    rx_at = fcyc + (v.glitch ? 8 : 4);
    if (v.glitch) rxl[fcyc + 1] = 1'b0;
    for (int j = 0; j < v.nreply; j++) put_byte(rx_at + j*44, v.reply[8*j +: 8], j == v.bad_idx);
    sel = v.use_b;
    if (v.glitch) begin
      rx = 1'b0; @(negedge clk); rx = 1'b1;
      repeat (12) @(negedge clk);
    end
    w = 0;
    while (!m_ack && w < 2000) begin @(negedge clk); w++; end
    if (!m_ack) begin
      chk({tag, "_ack_wait"}, m_ack, 1'b1);
      return;
    end
    we = v.we; addr = v.addr; wdata = v.wdata; req = 1'b1;
    lim = fcyc + (v.we ? 5 : tmo + 220);
    resp_n = 0; tx_bad = 0; ctl_bad = 0; rd_seen = '0; tmo_seen = 1'b0;
    for (int n = 1; n <= lim && resp_n == 0; n++) begin
      @(negedge clk);
      if (n == 1 && !v.hold) req = 1'b0;
      exp_tx = (n <= fcyc) ? eb[(n-1)/BAUD] : 1'b1;
      if (m_tx !== exp_tx) tx_bad++;
      if (m_resp === 1'b1) begin
        resp_n = n; rd_seen = m_rdata; tmo_seen = m_tmo;
        if (m_busy !== 1'b0 || m_ack !== 1'b0) ctl_bad++;
      end else if (m_busy !== 1'b1 || m_ack !== 1'b0 || m_tmo !== 1'b0) begin
        ctl_bad++;
      end
      rx = rxl[n];
    end
    rx = 1'b1;
    chk({tag, "_tx_bits"}, tx_bad, 0);
    chk({tag, "_busy_ack"}, ctl_bad, 0);
    if (resp_n == 0) begin
      chk({tag, "_resp_seen"}, 0, 1);
      return;
    end
    if (v.we) chk({tag, "_resp_cycle"}, resp_n, fcyc + 1);
    else if (v.exp_tmo) chk({tag, "_resp_cycle"}, resp_n, fcyc + 1 + tmo);
    else chk({tag, "_resp_window"}, (resp_n > rx_at + 160) && (resp_n <= rx_at + 180), 1);
    chk({tag, "_timeout"}, tmo_seen, v.we ? 1'b0 : v.exp_tmo);
    if (!v.we) chk({tag, "_rdata"}, rd_seen, v.exp_rdata);
    @(negedge clk);
    chk({tag, "_post"}, {m_ack, m_resp, m_busy, m_tmo}, 4'b1000);
    if (!v.we) chk({tag, "_rdata_hold"}, m_rdata, v.exp_rdata);
  endtask

  initial begin
    vec_t v;
    int   w;
    //        we addr          wdata         n reply         bad glt inj hold b  exp_rdata     tmo
    tbl[0] = '{1, 32'h80000000, 32'h000000A5, 0, 32'h0,        -1, 0, 0, 0, 0, 32'h0,        0};
    tbl[1] = '{0, 32'h80000004, 32'h0,        4, 32'h78563412, -1, 0, 0, 0, 0, 32'h78563412, 0};
    tbl[2] = '{0, 32'h00001000, 32'h0,        0, 32'h0,        -1, 0, 0, 0, 1, 32'hFFFFFFFF, 1};
    tbl[3] = '{0, 32'h00002000, 32'h0,        4, 32'h44332211,  1, 0, 0, 0, 0, 32'hFFFFFFFF, 1};
    tbl[4] = '{0, 32'hA5A5A5A5, 32'h0,        4, 32'hCAFEF00D, -1, 1, 0, 0, 0, 32'hCAFEF00D, 0};
    tbl[5] = '{1, 32'h12345678, 32'hDEADBEEF, 0, 32'h0,        -1, 0, 0, 1, 0, 32'h0,        0};
    tbl[6] = '{0, 32'hFFFF0000, 32'h0,        4, 32'h0BADC0DE, -1, 0, 1, 0, 0, 32'h0BADC0DE, 0};

    repeat (3) @(negedge clk);
    chk("rst_tx", tx_a, 1'b1);
    chk("rst_ack", ack_a, 1'b1);
    chk("rst_resp", resp_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_timeout", tmo_a, 1'b0);
    chk("rst_rdata", rdata_a, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      v.we = 1'($urandom_range(0, 1)); v.addr = $urandom; v.wdata = $urandom;
      v.nreply = v.we ? 0 : 4; v.reply = $urandom;
      v.bad_idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      v.glitch = 1'($urandom_range(0, 1)); v.inject = 1'b0; v.hold = 1'b0; v.use_b = 1'b0;
      model(v);
      run(v, $sformatf("rnd%0d", i));
    end

    // Abort a write during frame byte 5 (address bits 23:16), while tx sits in a start bit.
    sel = 1'b0;
    w = 0;
    while (!ack_a && w < 2000) begin @(negedge clk); w++; end
    we = 1'b1; addr = 32'h0; wdata = $urandom; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (161) @(negedge clk);
    chk("abort_pre_tx", tx_a, 1'b0);
    chk("abort_pre_busy", busy_a, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_tx", tx_a, 1'b1);
    chk("abort_ack", ack_a, 1'b1);
    chk("abort_resp", resp_a, 1'b0);
    chk("abort_busy", busy_a, 1'b0);
    chk("abort_timeout", tmo_a, 1'b0);
    chk("abort_rdata", rdata_a, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v = '{0, 32'h80000008, 32'h0, 4, 32'h5EC0FFEE, -1, 0, 0, 0, 0, 32'h0, 0};
    model(v);
    run(v, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
